// File: rtl/qpsk_pkg.sv
// rtl/qpsk_pkg.sv - shared types and constants for the QPSK symbol framer
package qpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SYNC,
    ST_PAYLOAD
  } state_t;

  localparam logic [1:0]  SYM_PRE_A         = 2'b00;
  localparam logic [1:0]  SYM_PRE_B         = 2'b10;
  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hD391;

  // Bit pair idx of a 16-bit word, MSB pair first (idx 0 -> [15:14]).
  function automatic logic [1:0] pair_of_word(input logic [15:0] w, input logic [2:0] idx);
    return 2'(w >> {~idx, 1'b0});
  endfunction

  // Bit pair idx of a byte, MSB pair first (idx 0 -> [7:6]).
  function automatic logic [1:0] pair_of_byte(input logic [7:0] b, input logic [1:0] idx);
    return 2'(b >> {~idx, 1'b0});
  endfunction

endpackage

// File: rtl/qpsk_byte_fifo.sv
// rtl/qpsk_byte_fifo.sv - single-clock show-ahead FIFO with count and registered ready
module qpsk_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             ready
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;
  logic [CW-1:0]    count_next;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign do_rd      = rd_en && !empty;
  assign do_wr      = wr_en && (!full || do_rd);
  assign count_next = count + CW'(do_wr) - CW'(do_rd);
  assign rd_data    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      // Ready tracks the post-update count so it is never stale by a cycle.
      ready <= (count_next != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/qpsk_symbol_framer.sv
// rtl/qpsk_symbol_framer.sv - byte-to-QPSK-symbol framer: preamble, sync word, payload
module qpsk_symbol_framer
  import qpsk_pkg::*;
#(
  parameter int          PREAMBLE_SYMS = 16,
  parameter logic [15:0] SYNC_WORD     = DEFAULT_SYNC_WORD,
  parameter int          FIFO_DEPTH    = 16,
  parameter int          START_THRESH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  input  logic       mod_req,
  output logic [1:0] symbol_out,
  output logic       symbol_en,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t     state_q;
  state_t     state_d;
  logic [4:0] pre_cnt;
  logic [2:0] sync_cnt;
  logic [1:0] pair_idx;
  logic [7:0] cur_byte;
  logic       cur_last;
  logic [CW-1:0] last_cnt;

  logic          wr_fire;
  logic          pop;
  logic [8:0]    fifo_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          start;

  logic [1:0] sym_d;
  logic       en_d;
  logic       done_d;
  logic       underrun_d;
  logic       need_byte;
  logic [4:0] pre_d;
  logic [2:0] sync_d;
  logic [1:0] pair_d;

  assign wr_fire = s_valid && s_ready && !fifo_full;

  qpsk_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_fire),
    .wr_data ({s_last, s_data}),
    .rd_en   (pop),
    .rd_data (fifo_q),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .ready   (s_ready)
  );

  // A buffered last-flagged byte means a whole frame is ready, regardless of threshold.
  assign start = (last_cnt != '0) || (fifo_count >= CW'(START_THRESH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mod_req) begin
      case (state_q)
        ST_IDLE:     if (start) state_d = ST_PREAMBLE;
        ST_PREAMBLE: if (pre_cnt == 5'(PREAMBLE_SYMS - 1)) state_d = ST_SYNC;
        ST_SYNC:     if (sync_cnt == 3'd7) state_d = fifo_empty ? ST_IDLE : ST_PAYLOAD;
        ST_PAYLOAD:  if (pair_idx == 2'd3 && (cur_last || fifo_empty)) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sym_d      = symbol_out;
    en_d       = symbol_en;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    need_byte  = 1'b0;
    pop        = 1'b0;
    pre_d      = pre_cnt;
    sync_d     = sync_cnt;
    pair_d     = pair_idx;
    if (mod_req) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sym_d = SYM_PRE_A;
            en_d  = 1'b1;
          end
        end
        ST_PREAMBLE: begin
          if (pre_cnt == 5'(PREAMBLE_SYMS - 1)) begin
            sym_d = pair_of_word(SYNC_WORD, 3'd0);
          end else begin
            sym_d = pre_cnt[0] ? SYM_PRE_A : SYM_PRE_B;
            pre_d = pre_cnt + 5'd1;
          end
        end
        ST_SYNC: begin
          if (sync_cnt == 3'd7) begin
            need_byte = 1'b1;
          end else begin
            sym_d  = pair_of_word(SYNC_WORD, sync_cnt + 3'd1);
            sync_d = sync_cnt + 3'd1;
          end
        end
        ST_PAYLOAD: begin
          if (pair_idx != 2'd3) begin
            sym_d  = pair_of_byte(cur_byte, pair_idx + 2'd1);
            pair_d = pair_idx + 2'd1;
          end else if (cur_last) begin
            sym_d  = 2'b00;
            en_d   = 1'b0;
            done_d = 1'b1;
          end else begin
            need_byte = 1'b1;
          end
        end
        default: begin
          sym_d = 2'b00;
          en_d  = 1'b0;
        end
      endcase
      if (need_byte) begin
        if (fifo_empty) begin
          sym_d      = 2'b00;
          en_d       = 1'b0;
          underrun_d = 1'b1;
        end else begin
          pop    = 1'b1;
          sym_d  = fifo_q[7:6];
          en_d   = 1'b1;
          pair_d = 2'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      symbol_out <= 2'b00;
      symbol_en  <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      busy       <= 1'b0;
      pre_cnt    <= '0;
      sync_cnt   <= '0;
      pair_idx   <= '0;
      cur_byte   <= '0;
      cur_last   <= 1'b0;
      last_cnt   <= '0;
    end else begin
      symbol_out <= sym_d;
      symbol_en  <= en_d;
      frame_done <= done_d;
      underrun   <= underrun_d;
      busy       <= (state_d != ST_IDLE);
      if (state_d != state_q) begin
        pre_cnt  <= '0;
        sync_cnt <= '0;
        pair_idx <= '0;
      end else begin
        pre_cnt  <= pre_d;
        sync_cnt <= sync_d;
        pair_idx <= pair_d;
      end
      if (pop) begin
        cur_byte <= fifo_q[7:0];
        cur_last <= fifo_q[8];
      end
      last_cnt <= last_cnt + CW'(wr_fire && s_last) - CW'(pop && fifo_q[8]);
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_framer.sv
// tb/tb_qpsk_symbol_framer.sv - randomized self-checking bench for qpsk_symbol_framer
module tb_qpsk_symbol_framer;

  localparam int          PRE  = 16;
  localparam logic [15:0] SYNC = 16'hD391;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic       mod_req = 1'b0;
  logic [1:0] symbol_out;
  logic       symbol_en;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  int checks = 0;
  int failures = 0;

  logic [7:0] frame_bytes[$];
  logic       frame_last;
  logic [1:0] exp_syms[$];

  qpsk_symbol_framer #(
    .PREAMBLE_SYMS (PRE),
    .SYNC_WORD     (SYNC),
    .FIFO_DEPTH    (16),
    .START_THRESH  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .mod_req    (mod_req),
    .symbol_out (symbol_out),
    .symbol_en  (symbol_en),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_expected();
    exp_syms.delete();
    for (int i = 0; i < PRE; i++) exp_syms.push_back((i % 2) ? 2'd2 : 2'd0);
    for (int i = 0; i < 8; i++) exp_syms.push_back(2'((SYNC >> (14 - 2 * i)) & 16'h3));
    foreach (frame_bytes[b])
      for (int k = 0; k < 4; k++) exp_syms.push_back(2'((frame_bytes[b] >> (6 - 2 * k)) & 8'h3));
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int w = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && w < 200) begin
      tick();
      w++;
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: s_ready=%0b required=1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic push_frame();
    foreach (frame_bytes[i]) push(frame_bytes[i], frame_last && (i == frame_bytes.size() - 1));
  endtask

  // Strobes mod_req through a whole frame plus its terminating strobe, checking each symbol.
  task automatic run_frame(input int gap, input int b2b, input bit ready_check);
    int n;
    build_expected();
    n = exp_syms.size();
    for (int i = 0; i <= n; i++) begin
      mod_req = 1'b1;
      tick();
      checks++;
      if (i < n) begin
        if ({symbol_en, symbol_out, busy} !== {1'b1, exp_syms[i], 1'b1}) begin
          failures++;
          $display("FAIL sym[%0d]: en/sym/busy=%0b/%0d/%0b required 1/%0d/1", i, symbol_en, symbol_out, busy, exp_syms[i]);
        end
      end else if ({symbol_en, busy, frame_done, underrun} !== {1'b0, 1'b0, frame_last, !frame_last}) begin
        failures++;
        $display("FAIL frame_end: en/busy/done/underrun=%0b/%0b/%0b/%0b required 0/0/%0b/%0b",
                 symbol_en, busy, frame_done, underrun, frame_last, !frame_last);
      end
      if (ready_check && i == PRE + 8) begin
        checks++;
        if (s_ready !== 1'b1) begin
          failures++;
          $display("FAIL ready_after_pop: s_ready=%0b required=1", s_ready);
        end
      end
      if (i + 1 < b2b) continue;
      mod_req = 1'b0;
      if (i == n) begin
        tick();
        checks++;
        if ({frame_done, underrun} !== 2'b00) begin
          failures++;
          $display("FAIL pulse_width: done/underrun=%0b/%0b required 0/0", frame_done, underrun);
        end
      end else if (gap > 0) begin
        repeat (gap) tick();
        checks++;
        if ({symbol_en, symbol_out} !== {1'b1, exp_syms[i]}) begin
          failures++;
          $display("FAIL hold[%0d]: en/sym=%0b/%0d required 1/%0d", i, symbol_en, symbol_out, exp_syms[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({symbol_out, symbol_en, busy, frame_done, underrun, s_ready} !== 7'b0) begin
      failures++;
      $display("FAIL reset_values: sym/en/busy/done/und/ready=%0d/%0b/%0b/%0b/%0b/%0b required all 0",
               symbol_out, symbol_en, busy, frame_done, underrun, s_ready);
    end
    reset = 1'b1;
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_at_release: s_ready=%0b required=0", s_ready);
    end
    tick();
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_release: s_ready=%0b required=1", s_ready);
    end
  endtask

  task automatic test_single_byte();
    frame_bytes = '{8'hB4};
    frame_last  = 1'b1;
    push_frame();
    run_frame(99, 0, 0);
  endtask

  task automatic test_threshold();
    frame_bytes.delete();
    for (int i = 0; i < 4; i++) frame_bytes.push_back(8'($urandom));
    frame_last = 1'b0;
    for (int i = 0; i < 3; i++) push(frame_bytes[i], 1'b0);
    mod_req = 1'b1;
    tick();
    mod_req = 1'b0;
    checks++;
    if ({symbol_en, busy, frame_done, underrun} !== 4'b0) begin
      failures++;
      $display("FAIL below_thresh: en/busy/done/und=%0b/%0b/%0b/%0b required 0/0/0/0",
               symbol_en, busy, frame_done, underrun);
    end
    push(frame_bytes[3], 1'b0);
    run_frame(4, 0, 0);
  endtask

  task automatic test_underrun();
    frame_bytes.delete();
    for (int i = 0; i < 4; i++) frame_bytes.push_back(8'($urandom));
    frame_last = 1'b0;
    push_frame();
    run_frame($urandom_range(1, 5), 0, 0);
  endtask

  task automatic test_fifo_full();
    int acc = 0;
    int cyc = 0;
    frame_bytes.delete();
    for (int i = 0; i < 20; i++) frame_bytes.push_back(8'($urandom));
    frame_last = 1'b1;
    s_valid = 1'b1;
    s_data  = frame_bytes[0];
    s_last  = 1'b0;
    while (cyc < 40) begin
      if (s_ready) begin
        tick();
        acc++;
        if (acc == 16) begin
          checks++;
          if (s_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready: s_ready=%0b required=0 after 16 bytes", s_ready);
          end
        end
        s_data = frame_bytes[acc];
        s_last = (acc == 19);
      end else begin
        tick();
      end
      cyc++;
    end
    checks++;
    if (acc != 16) begin
      failures++;
      $display("FAIL full_accepted: accepted=%0d required=16", acc);
    end
    fork
      begin
        cyc = 0;
        while (acc < 20 && cyc < 5000) begin
          if (s_ready) begin
            tick();
            acc++;
            if (acc < 20) begin
              s_data = frame_bytes[acc];
              s_last = (acc == 19);
            end
          end else begin
            tick();
          end
          cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++;
        if (acc != 20) begin
          failures++;
          $display("FAIL refill: accepted=%0d required=20", acc);
        end
      end
      run_frame(3, 0, 1);
    join
  endtask

  task automatic test_reset_mid_payload();
    frame_bytes = '{8'($urandom), 8'($urandom)};
    frame_last  = 1'b1;
    push_frame();
    for (int i = 0; i < PRE + 8 + 2; i++) begin
      mod_req = 1'b1;
      tick();
      mod_req = 1'b0;
      tick();
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({symbol_out, symbol_en, busy, frame_done, underrun, s_ready} !== 7'b0) begin
      failures++;
      $display("FAIL async_reset: sym/en/busy/done/und/ready=%0d/%0b/%0b/%0b/%0b/%0b required all 0",
               symbol_out, symbol_en, busy, frame_done, underrun, s_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({frame_done, underrun} !== 2'b00) begin
        failures++;
        $display("FAIL reset_pulse: done/und=%0b/%0b required 0/0", frame_done, underrun);
      end
    end
    reset = 1'b1;
    tick();
    frame_bytes = '{8'($urandom)};
    frame_last  = 1'b1;
    push_frame();
    run_frame(2, 0, 0);
  endtask

  task automatic test_back_to_back();
    frame_bytes = '{8'($urandom), 8'($urandom)};
    frame_last  = 1'b1;
    push_frame();
    run_frame(2, 30, 0);
  endtask

  task automatic test_random_frames();
    int len;
    for (int r = 0; r < 4; r++) begin
      frame_last = ($urandom_range(0, 3) != 0);
      len = frame_last ? $urandom_range(1, 6) : $urandom_range(4, 8);
      frame_bytes.delete();
      for (int i = 0; i < len; i++) frame_bytes.push_back(8'($urandom));
      push_frame();
      run_frame($urandom_range(1, 6), 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_threshold();
    test_underrun();
    test_fifo_full();
    test_reset_mid_payload();
    test_back_to_back();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
